// File: rtl/pe_pkg.sv
// Shared types and helpers for the grant controller: FSM state encoding,
// requester count/index width, and one-hot <-> index conversion.
package pe_pkg;

    localparam int PE_NUM_REQ = 3;
    localparam int PE_ID_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } pe_state_e;

    // Highest set bit wins, so a multi-hot vector still yields a defined index.
    function automatic logic [PE_ID_W-1:0] pe_onehot_to_idx(input logic [PE_NUM_REQ-1:0] vec);
        logic [PE_ID_W-1:0] idx;
        idx = '0;
        if (vec[2]) begin
            idx = 2'd2;
        end else if (vec[1]) begin
            idx = 2'd1;
        end
        return idx;
    endfunction

    function automatic logic [PE_NUM_REQ-1:0] pe_idx_to_onehot(input logic [PE_ID_W-1:0] idx);
        logic [PE_NUM_REQ-1:0] vec;
        vec = '0;
        case (idx)
            2'd0:    vec = 3'b001;
            2'd1:    vec = 3'b010;
            2'd2:    vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/pe_onehot_enc.sv
// Combinational classifier of the 3-bit request vector: index, empty and multi-hot flags.
// Latency 0; no flow control.
module pe_onehot_enc
    import pe_pkg::*;
(
    input  logic [PE_NUM_REQ-1:0] vec_i,
    output logic [PE_ID_W-1:0]    id_o,
    output logic                  is_zero_o,
    output logic                  is_multihot_o
);

    assign id_o          = pe_onehot_to_idx(vec_i);
    assign is_zero_o     = (vec_i == '0);
    // Clearing the lowest set bit leaves something behind only when two or more bits are set.
    assign is_multihot_o = ((vec_i & (vec_i - 3'd1)) != '0);

endmodule

// File: rtl/pe_grant_ctrl.sv
// Grant controller: latches a one-hot request, holds it until ack, waits for the request to drop.
// Latency: grant 1 cycle after request; holds the grant until ack (or timeout with PE_GRANT_TIMEOUT_EN).
module pe_grant_ctrl
    import pe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PE_NUM_REQ-1:0] req_onehot,
    input  logic                  ack,
    output logic                  grant_valid,
    output logic [PE_ID_W-1:0]    grant_id,
    output logic [PE_NUM_REQ-1:0] grant_onehot,
    output logic                  err_multihot,
    output logic                  timeout,
    output logic [7:0]            grant_count
);

    pe_state_e             state_q, state_d;
    logic                  vld_q, vld_d;
    logic [PE_ID_W-1:0]    id_q, id_d;
    logic [PE_NUM_REQ-1:0] held_q, held_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [PE_ID_W-1:0]    enc_id;
    logic                  enc_zero;
    logic                  enc_multi;

    pe_onehot_enc u_enc (
        .vec_i         (req_onehot),
        .id_o          (enc_id),
        .is_zero_o     (enc_zero),
        .is_multihot_o (enc_multi)
    );

`ifdef PE_GRANT_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tcnt_q, tcnt_d;
    logic       tmo_q, tmo_d;

    // Counts consecutive un-acked cycles spent in GRANT; zero in every other state.
    assign tcnt_d = (state_q == ST_GRANT) ? tcnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 8'd0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    logic [7:0] unused_tmo_cfg;
    assign unused_tmo_cfg = 8'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        id_d    = id_q;
        held_d  = held_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef PE_GRANT_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!enc_zero) begin
                    if (enc_multi) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_GRANT;
                        vld_d   = 1'b1;
                        id_d    = enc_id;
                        held_d  = req_onehot;
                    end
                end
            end
            ST_GRANT: begin
                // ack is checked first so it wins over an expiring timer.
                if (ack) begin
                    state_d = ST_RELEASE;
                    vld_d   = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                end
`ifdef PE_GRANT_TIMEOUT_EN
                else if (tcnt_q == TMO_LAST) begin
                    state_d = ST_RELEASE;
                    vld_d   = 1'b0;
                    tmo_d   = 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                // Block re-grant until the served requester has dropped its bit.
                if ((req_onehot & held_q) == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            id_q    <= '0;
            held_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            held_q  <= held_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_valid  = vld_q;
    assign grant_id     = id_q;
    assign grant_onehot = vld_q ? pe_idx_to_onehot(id_q) : '0;
    assign err_multihot = err_q;
    assign grant_count  = cnt_q;

endmodule

// File: tb/tb_pe_grant_ctrl.sv
// Bench for pe_grant_ctrl: stimulus queues expected grant/release/error events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pe_grant_ctrl;

    localparam int EV_GRANT = 0;
    localparam int EV_REL   = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int         kind;
        logic [1:0] id;
        logic [2:0] oh;
        logic [7:0] cnt;
        logic       tmo;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] req_onehot;
    logic       ack;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [2:0] grant_onehot;
    logic       err_multihot;
    logic       timeout;
    logic [7:0] grant_count;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [7:0] exp_cnt;
    logic prev_vld;

    pe_grant_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_onehot   (req_onehot),
        .ack          (ack),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .grant_onehot (grant_onehot),
        .err_multihot (err_multihot),
        .timeout      (timeout),
        .grant_count  (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int kind, input logic [1:0] id, input logic [2:0] oh,
                                input logic [7:0] cnt, input logic tmo);
        exp_t e;
        e.kind = kind;
        e.id   = id;
        e.oh   = oh;
        e.cnt  = cnt;
        e.tmo  = tmo;
        return e;
    endfunction

    task automatic pop_expect(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = mk(0, 2'd0, 3'd0, 8'd0, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual=kind%0d required=none", kind);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_kind actual=%0d required=%0d", kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: rising grant_valid, falling grant_valid and err pulses are the observable events.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!rst || grant_valid !== prev_vld) begin
            if (grant_valid === 1'b1 && prev_vld === 1'b0) begin
                pop_expect(EV_GRANT, e, ok);
                if (ok) begin
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                    chk("grant_onehot", 32'(grant_onehot), 32'(e.oh));
                end
            end
            if (grant_valid === 1'b0 && prev_vld === 1'b1) begin
                pop_expect(EV_REL, e, ok);
                if (ok) begin
                    chk("rel_count", 32'(grant_count), 32'(e.cnt));
                    chk("rel_timeout", 32'(timeout), 32'(e.tmo));
                    chk("rel_onehot_zero", 32'(grant_onehot), 32'd0);
                end
            end
            if (err_multihot === 1'b1) begin
                pop_expect(EV_ERR, e, ok);
                if (ok) chk("err_no_grant", 32'(grant_valid), 32'd0);
            end
        end
        prev_vld <= grant_valid;
    end

    // One full acked grant of a legal request, ending back in IDLE.
    task automatic do_grant(input logic [2:0] r, input logic [1:0] id);
        req_onehot = r;
        exp_q.push_back(mk(EV_GRANT, id, r, 8'd0, 1'b0));
        tick();
        ack = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back(mk(EV_REL, 2'd0, 3'd0, exp_cnt, 1'b0));
        tick();
        ack = 1'b0;
        req_onehot = 3'b000;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, "_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_onehot"}, 32'(grant_onehot), 32'd0);
        chk({tag, "_err"}, 32'(err_multihot), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_count"}, 32'(grant_count), 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_cnt    = 8'd0;
        prev_vld   = 1'b0;
        rst        = 1'b1;
        req_onehot = 3'b000;
        ack        = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Single grant of requester 1; request changes during GRANT must not disturb it.
        req_onehot = 3'b010;
        exp_q.push_back(mk(EV_GRANT, 2'd1, 3'b010, 8'd0, 1'b0));
        tick();
        chk("grant_latency", 32'(grant_valid), 32'd1);
        req_onehot = 3'b100;
        tick();
        chk("stable_id", 32'(grant_id), 32'd1);
        chk("stable_onehot", 32'(grant_onehot), 32'b010);
        req_onehot = 3'b010;
        ack = 1'b1;
        exp_cnt = 8'd1;
        exp_q.push_back(mk(EV_REL, 2'd0, 3'd0, exp_cnt, 1'b0));
        tick();
        ack = 1'b0;
        chk("count_after_ack", 32'(grant_count), 32'd1);

        // Held request stays blocked; ack in RELEASE is ignored.
        for (int i = 0; i < 4; i++) begin
            ack = (i == 1);
            tick();
            chk("held_no_regrant", 32'(grant_valid), 32'd0);
        end
        ack = 1'b0;
        chk("ack_ignored_release", 32'(grant_count), 32'd1);
        req_onehot = 3'b000;
        tick();
        req_onehot = 3'b100;
        exp_q.push_back(mk(EV_GRANT, 2'd2, 3'b100, 8'd0, 1'b0));
        tick();
        chk("second_grant_id", 32'(grant_id), 32'd2);
        ack = 1'b1;
        exp_cnt = 8'd2;
        exp_q.push_back(mk(EV_REL, 2'd0, 3'd0, exp_cnt, 1'b0));
        tick();
        ack = 1'b0;
        req_onehot = 3'b000;
        tick();

        // Multi-hot vectors: one-cycle error pulse each, never a grant.
        req_onehot = 3'b011;
        exp_q.push_back(mk(EV_ERR, 2'd0, 3'd0, 8'd0, 1'b0));
        tick();
        chk("err_pulse_011", 32'(err_multihot), 32'd1);
        req_onehot = 3'b000;
        tick();
        chk("err_one_cycle", 32'(err_multihot), 32'd0);
        chk("err_valid_low", 32'(grant_valid), 32'd0);
        req_onehot = 3'b111;
        exp_q.push_back(mk(EV_ERR, 2'd0, 3'd0, 8'd0, 1'b0));
        tick();
        chk("err_pulse_111", 32'(err_multihot), 32'd1);
        req_onehot = 3'b000;
        tick();

        // ack already high on the entry cycle is not consumed by the entry itself.
        ack = 1'b1;
        req_onehot = 3'b001;
        exp_q.push_back(mk(EV_GRANT, 2'd0, 3'b001, 8'd0, 1'b0));
        tick();
        chk("ack_entry_valid", 32'(grant_valid), 32'd1);
        chk("ack_entry_count", 32'(grant_count), 32'd2);
        exp_cnt = 8'd3;
        exp_q.push_back(mk(EV_REL, 2'd0, 3'd0, exp_cnt, 1'b0));
        tick();
        ack = 1'b0;
        req_onehot = 3'b000;
        tick();

        // Timeout behaviour (or indefinite wait when the feature is absent).
        req_onehot = 3'b010;
        exp_q.push_back(mk(EV_GRANT, 2'd1, 3'b010, 8'd0, 1'b0));
        tick();
`ifdef PE_GRANT_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk("before_expiry_valid", 32'(grant_valid), 32'd1);
        exp_q.push_back(mk(EV_REL, 2'd0, 3'd0, exp_cnt, 1'b1));
        tick();
        chk("timeout_pulse", 32'(timeout), 32'd1);
        chk("timeout_count_kept", 32'(grant_count), 32'(exp_cnt));
        req_onehot = 3'b000;
        tick();
        chk("timeout_one_cycle", 32'(timeout), 32'd0);
        req_onehot = 3'b100;
        exp_q.push_back(mk(EV_GRANT, 2'd2, 3'b100, 8'd0, 1'b0));
        tick();
        tick();
        tick();
        tick();
        ack = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back(mk(EV_REL, 2'd0, 3'd0, exp_cnt, 1'b0));
        tick();
        ack = 1'b0;
        chk("ack_wins_timeout", 32'(timeout), 32'd0);
        chk("ack_wins_count", 32'(grant_count), 32'(exp_cnt));
`else
        for (int i = 0; i < 20; i++) tick();
        chk("no_timeout_valid", 32'(grant_valid), 32'd1);
        chk("no_timeout_flag", 32'(timeout), 32'd0);
        ack = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back(mk(EV_REL, 2'd0, 3'd0, exp_cnt, 1'b0));
        tick();
        ack = 1'b0;
`endif
        req_onehot = 3'b000;
        tick();

        // Run the count to 256 acked grants so it wraps to zero.
        while (exp_cnt != 8'd0) begin
            case (exp_cnt % 3)
                0:       do_grant(3'b001, 2'd0);
                1:       do_grant(3'b010, 2'd1);
                default: do_grant(3'b100, 2'd2);
            endcase
        end
        chk("count_wrap", 32'(grant_count), 32'd0);

        // Reset while granted with ack high: grant abandoned, count not incremented.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_onehot = 3'b100;
        exp_q.push_back(mk(EV_GRANT, 2'd2, 3'b100, 8'd0, 1'b0));
        tick();
        rst = 1'b1;
        ack = 1'b1;
        exp_q.push_back(mk(EV_REL, 2'd0, 3'd0, 8'd0, 1'b0));
        tick();
        chk_reset_outputs("rst_in_grant");
        rst = 1'b0;
        ack = 1'b0;
        req_onehot = 3'b000;
        tick();
        tick();
        chk("count_after_rst", 32'(grant_count), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_grant_ctrl.md
PE_GRANT_CTRL -- requirements
Module: pe_grant_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, SHALL set the number of cycles without ack before a timeout (range 1..255).
REQ-003 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-004 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port req_onehot, input, 3 bits, SHALL carry the one-hot priority vector from the upstream priority encoder. Bit 2 is the highest priority.
REQ-006 Port ack, input, 1 bit, SHALL be the consumer's acknowledge of the current grant.
REQ-007 Port grant_valid, output, 1 bit, SHALL be high while a grant is outstanding.
REQ-008 Port grant_id, output, 2 bits, SHALL give the binary index (0..2) of the granted requester.
REQ-009 Port grant_onehot, output, 3 bits, SHALL give the one-hot form of grant_id, or 000 when there is no grant.
REQ-010 Port err_multihot, output, 1 bit, SHALL pulse for one cycle when an illegal input vector is sampled in IDLE.
REQ-011 Port timeout, output, 1 bit, SHALL pulse for one cycle when a grant expires (only when the feature is compiled in).
REQ-012 Port grant_count, output, 8 bits, SHALL count completed (acked) grants.

Function
REQ-013 The FSM states SHALL be IDLE, GRANT and RELEASE.
REQ-014 In IDLE, a legal one-hot req_onehot SHALL latch the vector and move to GRANT. grant_valid, grant_id and grant_onehot are registered and assert on the next edge, giving 1-cycle latency.
REQ-015 In IDLE, req_onehot = 000 SHALL keep the FSM in IDLE with no outputs changing.
REQ-016 In IDLE, a multi-hot req_onehot (for example 011 or 111) SHALL produce no grant, pulse err_multihot for one cycle, and keep the FSM in IDLE.
REQ-017 In GRANT, grant_id and grant_onehot SHALL stay stable regardless of changes on req_onehot.
REQ-018 In GRANT, ack = 1 SHALL deassert grant_valid on the next edge, increment grant_count modulo 256 (255 -> 0), and move to RELEASE.
REQ-019 ack SHALL be ignored in IDLE and RELEASE. ack has no effect on the cycle in which the FSM enters GRANT, because it is sampled only while grant_valid = 1.
REQ-020 In RELEASE, the FSM SHALL stay until the previously granted bit of req_onehot is 0, then go to IDLE. A held request is therefore never re-granted back-to-back.
REQ-021 A new request SHALL be evaluated in IDLE no earlier than the cycle after RELEASE exits. The minimum grant-to-grant spacing is 3 cycles.
REQ-022 grant_onehot SHALL always equal the decode of grant_id when grant_valid = 1, and 000 otherwise.

Reset
REQ-023 rst = 1 on a clock edge SHALL force IDLE, grant_valid = 0, grant_id = 0, grant_onehot = 000, err_multihot = 0, timeout = 0, grant_count = 0, and clear the timeout counter.
REQ-024 rst asserted in GRANT or RELEASE SHALL abandon the grant without incrementing grant_count, and rst SHALL take priority over ack in the same cycle.

Configuration
REQ-025 Macro PE_GRANT_TIMEOUT_EN SHALL control the grant-timeout feature.
REQ-026 With PE_GRANT_TIMEOUT_EN defined, a counter SHALL run in GRANT. After TIMEOUT_CYCLES consecutive cycles without ack, the block SHALL deassert grant_valid, pulse timeout, leave grant_count unchanged, and go to RELEASE.
REQ-027 If ack arrives in the same cycle the count expires, ack SHALL win.
REQ-028 Without PE_GRANT_TIMEOUT_EN, there SHALL be no counter, timeout SHALL be tied to 0, and GRANT SHALL wait for ack indefinitely.

Structure
REQ-029 Shared package pe_pkg SHALL hold the FSM state typedef, the constant PE_NUM_REQ = 3, the constant PE_ID_W = 2, and a onehot-to-index function.
REQ-030 Sub-module pe_onehot_enc SHALL be purely combinational. It SHALL map the 3-bit vector to grant_id plus is_zero and is_multihot flags.

Verification
REQ-031 Scenario: after reset, req = 010 in IDLE -> next cycle grant_valid = 1, grant_id = 1, grant_onehot = 010.
REQ-032 Scenario: in GRANT, ack = 1 -> grant_valid = 0 next cycle and grant_count goes 0 -> 1. Then req held at 010 -> no new grant until req = 000, after which req = 100 gives grant_id = 2.
REQ-033 Scenario: req = 011 in IDLE -> err_multihot = 1 for exactly 1 cycle and grant_valid stays 0.
REQ-034 Scenario: complete 256 acked grants -> grant_count wraps from 255 to 0.
REQ-035 Scenario (PE_GRANT_TIMEOUT_EN, TIMEOUT_CYCLES = 4): grant with no ack -> timeout pulses after 4 cycles, grant_valid = 0, grant_count unchanged. With ack on the expiry cycle -> no timeout and the count increments.
REQ-036 Scenario: rst = 1 while in GRANT with ack = 1 -> all outputs return to reset values and grant_count stays 0.
